// File: rtl/ps2_port.sv
// ps2_port: CSR-mapped PS/2 host controller.
//
// Receives 11-bit device frames and transmits host-to-device command bytes
// over the open-drain PS/2 clock and data lines. A one-cycle irq pulse marks
// either a correctly received byte or the end of a transmission.
//
// Parameters:
//   csr_addr  CSR bank id, compared against csr_a[13:10]
//   clk_freq  sys_clk frequency in Hz; sets the inhibit and timeout counts
//
// Ports:
//   sys_clk   system clock, rising edge
//   sys_rst   asynchronous active-low reset
//   csr_a     CSR address; [13:10] bank select, [0] register offset
//   csr_we    CSR write strobe
//   csr_di    CSR write data
//   csr_do    registered CSR read data (0 when the bank is not selected)
//   ps2_clk   open-drain PS/2 clock (drives 0 or releases)
//   ps2_data  open-drain PS/2 data (drives 0 or releases)
//   irq       one-cycle interrupt pulse
//
// Register map:
//   offset 0  read  {24'b0, rx_data}, clears rx_valid
//             write start transmission of csr_di[7:0] when tx is idle
//   offset 1  read  {30'b0, rx_valid, tx_busy}

module ps2_port #(
    parameter logic [3:0] csr_addr = 4'h0,
    parameter int         clk_freq = 50000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    inout  wire         ps2_clk,
    inout  wire         ps2_data,
    output logic        irq
);

    localparam int INHIBIT_CYCLES = clk_freq / 10000;
    localparam int RX_TIMEOUT     = clk_freq / 5000;
    localparam int TX_TIMEOUT     = clk_freq / 500;
    localparam int TX_CNT_W       = $clog2(TX_TIMEOUT + 1);
    localparam int RX_CNT_W       = $clog2(RX_TIMEOUT + 1);

    localparam logic [TX_CNT_W-1:0] INHIBIT_LAST = TX_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [TX_CNT_W-1:0] TX_LAST      = TX_CNT_W'(TX_TIMEOUT - 1);
    localparam logic [RX_CNT_W-1:0] RX_LAST      = RX_CNT_W'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_INHIBIT,
        TX_START,
        TX_BITS,
        TX_ACK
    } tx_state_t;

    tx_state_t tx_state, tx_next;

    logic [2:0]          clk_sync;
    logic [1:0]          data_sync;
    logic                fall;
    logic                data_in;

    logic                sel;
    logic                tx_start;
    logic                rd_data;
    logic [9:0]          tx_frame;
    logic [3:0]          tx_idx;
    logic [TX_CNT_W-1:0] tx_cnt;
    logic                tx_timeout;
    logic                tx_busy;
    logic                tx_done;
    logic                clk_low;
    logic                data_low;

    logic [3:0]          rx_cnt;
    logic [8:0]          rx_shift;
    logic [RX_CNT_W-1:0] rx_timer;
    logic                rx_done;
    logic [7:0]          rx_data;
    logic                rx_valid;

    // Bus bits the register map does not decode.
    logic                unused_bits;
    assign unused_bits = ^{csr_di[31:8], csr_a[9:1]};

    assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = data_low ? 1'b0 : 1'bz;

    assign sel      = (csr_a[13:10] == csr_addr);
    assign tx_start = sel & csr_we & ~csr_a[0] & (tx_state == TX_IDLE);
    assign rd_data  = sel & ~csr_we & ~csr_a[0];

    // Synchroniser; the third clock stage gives the previous value for edge
    // detection. Lines idle high, so reset to 1 to avoid a false edge.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign data_in = data_sync[1];

    assign tx_timeout = (tx_cnt == TX_LAST);

    // Transmit state register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // Transmit next-state logic; a device clock edge takes priority over
    // a timeout that expires in the same cycle.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: begin
                if (tx_start) tx_next = TX_INHIBIT;
            end
            TX_INHIBIT: begin
                if (tx_cnt == INHIBIT_LAST) tx_next = TX_START;
            end
            TX_START: begin
                if (fall)            tx_next = TX_BITS;
                else if (tx_timeout) tx_next = TX_IDLE;
            end
            TX_BITS: begin
                if (fall) begin
                    if (tx_idx == 4'd9) tx_next = TX_ACK;
                end else if (tx_timeout) begin
                    tx_next = TX_IDLE;
                end
            end
            TX_ACK: begin
                if (fall || tx_timeout) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Transmit outputs. The frame holds data, parity and a stop bit of 1,
    // so presenting the stop bit releases the data line.
    always_comb begin
        clk_low  = (tx_state == TX_INHIBIT);
        data_low = (tx_state == TX_START) ||
                   ((tx_state == TX_BITS) && !tx_frame[tx_idx]);
        tx_busy  = (tx_state != TX_IDLE);
        tx_done  = (tx_state != TX_IDLE) && (tx_next == TX_IDLE);
    end

    // One counter serves both the inhibit period and the device-clock
    // timeout: it restarts on every state change and every device edge.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            tx_cnt <= '0;
        end else if (tx_state != tx_next || tx_state == TX_IDLE) begin
            tx_cnt <= '0;
        end else if (fall && tx_state != TX_INHIBIT) begin
            tx_cnt <= '0;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    // Frame capture on an accepted write and bit index advance on device edges.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            tx_frame <= '1;
            tx_idx   <= '0;
        end else begin
            if (tx_start) begin
                tx_frame <= {1'b1, ~^csr_di[7:0], csr_di[7:0]};
            end
            if (fall && tx_state == TX_START) begin
                tx_idx <= 4'd0;
            end else if (fall && tx_state == TX_BITS && tx_idx != 4'd9) begin
                tx_idx <= tx_idx + 4'd1;
            end
        end
    end

    // Receive shifter. rx_cnt 0 waits for a start bit, 1..9 shift data and
    // parity in LSB first, 10 checks the stop bit. Suspended while transmitting;
    // a stalled frame is abandoned after the idle timeout.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_timer <= '0;
        end else if (tx_busy) begin
            rx_cnt   <= '0;
            rx_timer <= '0;
        end else if (fall) begin
            rx_timer <= '0;
            if (rx_cnt == 4'd0) begin
                if (!data_in) rx_cnt <= 4'd1;
            end else if (rx_cnt == 4'd10) begin
                rx_cnt <= 4'd0;
            end else begin
                rx_shift <= {data_in, rx_shift[8:1]};
                rx_cnt   <= rx_cnt + 4'd1;
            end
        end else if (rx_cnt != 4'd0) begin
            if (rx_timer == RX_LAST) begin
                rx_cnt   <= '0;
                rx_timer <= '0;
            end else begin
                rx_timer <= rx_timer + 1'b1;
            end
        end else begin
            rx_timer <= '0;
        end
    end

    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign rx_done = !tx_busy && fall && (rx_cnt == 4'd10) && data_in && (^rx_shift);

    // Received byte holding register; a new byte wins over a same-cycle read.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (rx_done) begin
            rx_data  <= rx_shift[7:0];
            rx_valid <= 1'b1;
        end else if (rd_data) begin
            rx_valid <= 1'b0;
        end
    end

    // Read data and interrupt, both registered.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            csr_do <= '0;
            irq    <= 1'b0;
        end else begin
            irq <= rx_done | tx_done;
            if (!sel) begin
                csr_do <= '0;
            end else if (csr_a[0]) begin
                csr_do <= {30'b0, rx_valid, tx_busy};
            end else begin
                csr_do <= {24'b0, rx_data};
            end
        end
    end

endmodule

// File: tb/tb_ps2_port.sv
// tb_ps2_port: directed self-checking bench for ps2_port.
// Models a PS/2 device on the pulled-up open-drain lines, clocking host
// transmissions and sending frames of its own.

module tb_ps2_port;

    localparam int HALF = 20;   // device half bit period in sys_clk cycles

    logic        sys_clk;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;
    wire         ps2_clk;
    wire         ps2_data;

    logic        dev_clk_low;
    logic        dev_data_low;

    int          test_count = 0;
    int          fail_count = 0;
    int          irq_count  = 0;

    pullup (ps2_clk);
    pullup (ps2_data);

    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    ps2_port #(
        .csr_addr (4'h0),
        .clk_freq (50000000)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_di   (csr_di),
        .csr_do   (csr_do),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .irq      (irq)
    );

    // 50 MHz system clock.
    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // Interrupt pulses are counted away from the active edge.
    always @(negedge sys_clk) begin
        if (irq === 1'b1) irq_count <= irq_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input logic [13:0] addr, input logic we,
                                 input logic [31:0] data);
        @(negedge sys_clk);
        csr_a  = addr;
        csr_we = we;
        csr_di = data;
    endtask

    // Device-to-host frame: start 0, data LSB first, parity, stop.
    // Only the first nbits bits are clocked to allow truncated frames.
    task automatic sendFrame(input logic [7:0] d, input logic par,
                             input logic stp, input int nbits);
        logic [10:0] frame;
        frame = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_data_low = ~frame[i];
            waitCycles(HALF);
            dev_clk_low = 1'b1;
            waitCycles(HALF);
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
        waitCycles(HALF);
    endtask

    // Host-to-device frame: 12 device clocks; bits after edges 1..10 are
    // captured, the ack is driven before the 12th edge.
    task automatic deviceReceive(output logic [9:0] bits);
        bits = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == 11) dev_data_low = 1'b1;
            waitCycles(HALF);
            dev_clk_low = 1'b1;
            waitCycles(HALF);
            if (k < 10) bits[k] = (ps2_data !== 1'b0);
            dev_clk_low = 1'b0;
        end
        waitCycles(HALF);
        dev_data_low = 1'b0;
    endtask

    initial begin
        int         irq_before;
        int         low_len;
        int         tries;
        int         low_seen;
        logic [9:0] tx_bits;

        sys_rst      = 1'b0;
        csr_a        = 14'h0001;
        csr_we       = 1'b0;
        csr_di       = '0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;

        // Reset state.
        #100;
        checkOutput("rst_csr_do", csr_do, 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_clk_released", 32'(ps2_clk), 32'h1);
        checkOutput("rst_data_released", 32'(ps2_data), 32'h1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        waitCycles(4);
        checkOutput("idle_status", csr_do, 32'h0);

        // Transmit 0x00: inhibit length, then start condition.
        irq_before = irq_count;
        applyStimulus(14'h0022, 1'b1, 32'h0);
        tries = 0;
        while (ps2_clk !== 1'b0 && tries < 20) begin
            @(negedge sys_clk);
            tries++;
        end
        low_len = 0;
        while (ps2_clk === 1'b0 && low_len < 6000) begin
            low_len++;
            @(negedge sys_clk);
        end
        checkOutput("inhibit_len", 32'(low_len), 32'd5000);
        checkOutput("start_data_low", 32'(ps2_data), 32'h0);
        checkOutput("start_clk_released", 32'(ps2_clk), 32'h1);

        // Writes while busy must not disturb the frame.
        applyStimulus(14'h0022, 1'b1, 32'hABCDEF78);
        waitCycles(2);
        applyStimulus(14'h0023, 1'b1, 32'hABCDEF78);
        waitCycles(2);
        checkOutput("busy_status", csr_do, 32'h1);
        applyStimulus(14'h0001, 1'b0, 32'h0);
        checkOutput("no_irq_before_ack", 32'(irq_count - irq_before), 32'h0);

        deviceReceive(tx_bits);
        waitCycles(10);
        checkOutput("tx_frame", 32'(tx_bits), 32'h300);
        checkOutput("tx_irq", 32'(irq_count - irq_before), 32'h1);
        checkOutput("tx_done_status", csr_do, 32'h0);

        // Good receive of 0x1C (three ones, parity 0).
        irq_before = irq_count;
        sendFrame(8'h1C, 1'b0, 1'b1, 11);
        waitCycles(5);
        checkOutput("rx_1c_irq", 32'(irq_count - irq_before), 32'h1);
        checkOutput("rx_1c_status", csr_do, 32'h2);
        applyStimulus(14'h0000, 1'b0, 32'h0);
        waitCycles(2);
        checkOutput("rx_1c_data", csr_do, 32'h1C);
        applyStimulus(14'h0001, 1'b0, 32'h0);
        waitCycles(2);
        checkOutput("rx_valid_cleared", csr_do, 32'h0);

        // Bad parity on 0x1C, then on 0x55: dropped, no irq.
        irq_before = irq_count;
        sendFrame(8'h1C, 1'b1, 1'b1, 11);
        waitCycles(5);
        checkOutput("bad_par_1c_irq", 32'(irq_count - irq_before), 32'h0);
        checkOutput("bad_par_1c_status", csr_do, 32'h0);
        sendFrame(8'h55, 1'b0, 1'b1, 11);
        waitCycles(5);
        checkOutput("bad_par_55_irq", 32'(irq_count - irq_before), 32'h0);
        applyStimulus(14'h0000, 1'b0, 32'h0);
        waitCycles(2);
        checkOutput("bad_par_data_kept", csr_do, 32'h1C);
        applyStimulus(14'h0001, 1'b0, 32'h0);

        // Good receive of 0xF0 (four ones, parity 1).
        irq_before = irq_count;
        sendFrame(8'hF0, 1'b1, 1'b1, 11);
        waitCycles(5);
        checkOutput("rx_f0_irq", 32'(irq_count - irq_before), 32'h1);
        checkOutput("rx_f0_status", csr_do, 32'h2);
        applyStimulus(14'h0000, 1'b0, 32'h0);
        waitCycles(2);
        checkOutput("rx_f0_data", csr_do, 32'hF0);
        applyStimulus(14'h0001, 1'b0, 32'h0);

        // Bad stop bit: dropped.
        irq_before = irq_count;
        sendFrame(8'h0F, 1'b1, 1'b0, 11);
        waitCycles(5);
        checkOutput("bad_stop_irq", 32'(irq_count - irq_before), 32'h0);

        // Truncated frame followed by the idle timeout, then a clean frame.
        irq_before = irq_count;
        sendFrame(8'h22, 1'b1, 1'b1, 4);
        waitCycles(10200);
        sendFrame(8'h22, 1'b1, 1'b1, 11);
        waitCycles(5);
        checkOutput("timeout_irq", 32'(irq_count - irq_before), 32'h1);
        applyStimulus(14'h0000, 1'b0, 32'h0);
        waitCycles(2);
        checkOutput("timeout_data", csr_do, 32'h22);

        // Other bank: reads return 0, writes do nothing on the lines.
        applyStimulus(14'h0400, 1'b0, 32'h0);
        waitCycles(2);
        checkOutput("desel_read", csr_do, 32'h0);
        applyStimulus(14'h0400, 1'b1, 32'h5A);
        low_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (ps2_clk === 1'b0) low_seen++;
        end
        checkOutput("desel_no_tx", 32'(low_seen), 32'h0);
        applyStimulus(14'h0001, 1'b0, 32'h0);
        waitCycles(2);
        checkOutput("desel_status", csr_do, 32'h0);

        $display("test done: total=%0d bad=%0d", test_count, fail_count);
        $finish;
    end

endmodule
